// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared types and constants for the HD44780 LCD sequencer:
//               FSM state encoding, peripheral-word field positions, the
//               power-on init command ROM and the slow-command opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

  // Width of the single shared down-counter (holds T_PWRUP-1 at 50 MHz)
  localparam int CNT_W = 20;

  // Field positions inside the 32-bit peripheral word
  localparam int DATA_LSB = 0;
  localparam int RS_BIT   = 8;
  localparam int TOG_BIT  = 10;
  localparam int BLON_BIT = 30;
  localparam int ON_BIT   = 31;

  // Commands that need the long execution wait
  localparam logic [7:0] OP_CLEAR     = 8'h01;
  localparam logic [7:0] OP_HOME      = 8'h02;
  localparam logic [7:0] OP_HOME_ALT  = 8'h03;

  // Power-on init sequence: 8-bit/2-line (x3), display on, clear, entry mode
  localparam int INIT_LEN = 6;
  localparam logic [0:INIT_LEN-1][7:0] INIT_ROM =
    {8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  typedef enum logic [2:0] {
    ST_PWRUP = 3'd0,
    ST_INIT  = 3'd1,
    ST_IDLE  = 3'd2,
    ST_SETUP = 3'd3,
    ST_PULSE = 3'd4,
    ST_HOLD  = 3'd5,
    ST_WAIT  = 3'd6
  } state_e;

  // Init ROM lookup; out-of-range indices return a harmless no-op value
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    if (idx < 3'(INIT_LEN)) return INIT_ROM[idx];
    else                    return 8'h00;
  endfunction

  // Clear and return-home commands execute far slower than the rest
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == OP_CLEAR) || (data == OP_HOME) || (data == OP_HOME_ALT));
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_timer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_timer
// Description : Loadable down-counter. A load of T-1 makes done_o read high
//               on the T-th cycle, so each phase lasts exactly T cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_timer
  import lcd_pkg::*;
#(
  parameter logic [CNT_W-1:0] RESET_VALUE = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  output logic             done_o
);

  logic [CNT_W-1:0] r_count;

  // Count down to zero and park there until the next load
  always_ff @(posedge clk_i) begin
    if (rst_i)                r_count <= RESET_VALUE;
    else if (load_i)          r_count <= value_i;
    else if (r_count != '0)   r_count <= r_count - CNT_W'(1);
  end

  assign done_o = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/lcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lcd_ctrl
// Description : HD44780 sequencer. Runs the power-on init autonomously, then
//               issues one LCD write per toggle of the request bit, with
//               setup / enable / hold / execution timing. All outputs are
//               registered.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned T_PWRUP = 750000,
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_EN    = 12,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_EXEC  = 2000,
  parameter int unsigned T_CLEAR = 82000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] io_lcd_i,
  output logic [7:0]  lcd_data_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic        lcd_en_o,
  output logic        lcd_on_o,
  output logic        lcd_blon_o,
  output logic        lcd_busy_o,
  output logic        lcd_ready_o
);

  localparam logic [CNT_W-1:0] c_pwrup_ld = CNT_W'(T_PWRUP - 1);
  localparam logic [CNT_W-1:0] c_setup_ld = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] c_en_ld    = CNT_W'(T_EN - 1);
  localparam logic [CNT_W-1:0] c_hold_ld  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] c_exec_ld  = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] c_clear_ld = CNT_W'(T_CLEAR - 1);
  localparam logic [2:0]       c_last_idx = 3'(INIT_LEN - 1);

  state_e           r_state, w_state_next;
  logic [7:0]       r_data;
  logic             r_rs, r_tog, r_ready, r_on, r_blon, r_en, r_busy;
  logic [2:0]       r_init_idx, w_init_idx_next;
  logic             w_done, w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_start_init, w_start_user, w_init_last, w_tog_pend;
  logic             w_en_next, w_busy_next;
  logic             w_unused_bits;

  assign w_tog_pend    = io_lcd_i[TOG_BIT] != r_tog;
  assign w_unused_bits = ^{io_lcd_i[29:11], io_lcd_i[9]};

  lcd_timer #(
    .RESET_VALUE (c_pwrup_ld)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (w_load),
    .value_i (w_load_val),
    .done_o  (w_done)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_PWRUP;
    else       r_state <= w_state_next;
  end

  // Next-state logic; INIT and the IDLE decision are folded into the cycle
  // that leaves the previous phase so no dead cycle is spent between
  // commands and a pending request keeps busy asserted without a gap.
  always_comb begin
    w_state_next    = r_state;
    w_load          = 1'b0;
    w_load_val      = c_setup_ld;
    w_start_init    = 1'b0;
    w_start_user    = 1'b0;
    w_init_last     = 1'b0;
    w_init_idx_next = r_init_idx;
    case (r_state)
      ST_PWRUP: if (w_done) w_start_init = 1'b1;
      ST_INIT:  w_start_init = 1'b1;
      ST_IDLE:  if (w_tog_pend) w_start_user = 1'b1;
      ST_SETUP: if (w_done) begin
        w_state_next = ST_PULSE;
        w_load       = 1'b1;
        w_load_val   = c_en_ld;
      end
      ST_PULSE: if (w_done) begin
        w_state_next = ST_HOLD;
        w_load       = 1'b1;
        w_load_val   = c_hold_ld;
      end
      ST_HOLD: if (w_done) begin
        w_state_next = ST_WAIT;
        w_load       = 1'b1;
        w_load_val   = is_long_cmd(r_rs, r_data) ? c_clear_ld : c_exec_ld;
      end
      ST_WAIT: if (w_done) begin
        if (!r_ready && (r_init_idx != c_last_idx)) begin
          w_init_idx_next = r_init_idx + 3'd1;
          w_start_init    = 1'b1;
        end else begin
          w_init_last = !r_ready;
          if (w_tog_pend) w_start_user = 1'b1;
          else            w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_PWRUP;
    endcase
    if (w_start_init || w_start_user) begin
      w_state_next = ST_SETUP;
      w_load       = 1'b1;
      w_load_val   = c_setup_ld;
    end
  end

  // Output decode from the upcoming state, registered below
  always_comb begin
    w_en_next   = (w_state_next == ST_PULSE);
    w_busy_next = (w_state_next != ST_IDLE);
  end

  // Capture registers, init index and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data     <= 8'h00;
      r_rs       <= 1'b0;
      r_tog      <= io_lcd_i[TOG_BIT];
      r_init_idx <= 3'd0;
      r_ready    <= 1'b0;
      r_on       <= 1'b0;
      r_blon     <= 1'b0;
      r_en       <= 1'b0;
      r_busy     <= 1'b1;
    end else begin
      r_on       <= io_lcd_i[ON_BIT];
      r_blon     <= io_lcd_i[BLON_BIT];
      r_en       <= w_en_next;
      r_busy     <= w_busy_next;
      r_init_idx <= w_init_idx_next;
      if (w_init_last) r_ready <= 1'b1;
      if (w_start_init) begin
        r_data <= init_cmd(w_init_idx_next);
        r_rs   <= 1'b0;
      end
      if (w_start_user) begin
        r_data <= io_lcd_i[DATA_LSB +: 8];
        r_rs   <= io_lcd_i[RS_BIT];
        r_tog  <= io_lcd_i[TOG_BIT];
      end
    end
  end

  assign lcd_data_o  = r_data;
  assign lcd_rs_o    = r_rs;
  assign lcd_rw_o    = 1'b0;
  assign lcd_en_o    = r_en;
  assign lcd_on_o    = r_on;
  assign lcd_blon_o  = r_blon;
  assign lcd_busy_o  = r_busy;
  assign lcd_ready_o = r_ready;

endmodule
`default_nettype wire
